// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, synchronises and
// debounces the active-low rows, and reports one accepted single-key press at a time.
module keypad_scan_debounce #(
  parameter int unsigned CLK_DIV        = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [1:0] item_selected
);

  localparam logic [15:0] PrescLast  = 16'(CLK_DIV - 1);
  localparam logic [7:0]  StableLast = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [7:0]  RelLast    = 8'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_meta_q, rs_q;
  logic [15:0] presc_q, presc_d;
  logic        tick;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_lat_q, row_lat_d;
  logic [7:0]  stable_q, stable_d;
  logic [7:0]  rel_q, rel_d;
  logic        single_key;
  logic [1:0]  row_idx;
  logic        accept, release_done;

  logic       key_valid_q, key_valid_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_held_q, key_held_d;
  logic [1:0] item_q, item_d;

  // Two-flop synchroniser; idles at all-ones (no key) so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q <= 4'b1111;
      rs_q       <= 4'b1111;
    end else begin
      row_meta_q <= row;
      rs_q       <= row_meta_q;
    end
  end

  assign tick    = (presc_q == PrescLast);
  assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // A sample is a single key only when exactly one row is pulled low.
  always_comb begin
    single_key = 1'b0;
    row_idx    = 2'd0;
    case (rs_q)
      4'b1110: begin single_key = 1'b1; row_idx = 2'd0; end
      4'b1101: begin single_key = 1'b1; row_idx = 2'd1; end
      4'b1011: begin single_key = 1'b1; row_idx = 2'd2; end
      4'b0111: begin single_key = 1'b1; row_idx = 2'd3; end
      default: begin single_key = 1'b0; row_idx = 2'd0; end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StScan;
      col_idx_q <= 2'd0;
      row_lat_q <= 2'd0;
      stable_q  <= 8'd0;
      rel_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_lat_q <= row_lat_d;
      stable_q  <= stable_d;
      rel_q     <= rel_d;
    end
  end

  // Next-state logic; nothing moves except on a scan tick.
  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    row_lat_d    = row_lat_q;
    stable_d     = stable_q;
    rel_d        = rel_q;
    accept       = 1'b0;
    release_done = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (single_key) begin
            row_lat_d = row_idx;
            stable_d  = 8'd0;
            state_d   = StDebounce;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        StDebounce: begin
          if (rs_q == ~(4'b0001 << row_lat_q)) begin
            stable_d = stable_q + 8'd1;
            if (stable_d == StableLast) begin
              state_d = StHeld;
              rel_d   = 8'd0;
              accept  = 1'b1;
            end
          end else begin
            state_d   = StScan;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        StHeld: begin
          if (rs_q == 4'b1111) begin
            rel_d = rel_q + 8'd1;
            if (rel_d == RelLast) begin
              state_d      = StScan;
              col_idx_d    = col_idx_q + 2'd1;
              rel_d        = 8'd0;
              release_done = 1'b1;
            end
          end else begin
            rel_d = 8'd0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // Output logic; the accepted code is simply {row, column} of the latched key.
  always_comb begin
    key_valid_d = accept;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    item_d      = item_q;
    if (accept) begin
      key_code_d = {row_lat_q, col_idx_q};
      key_held_d = 1'b1;
      case ({row_lat_q, col_idx_q})
        4'd0:    item_d = 2'b01;
        4'd1:    item_d = 2'b10;
        4'd2:    item_d = 2'b11;
        default: item_d = 2'b00;
      endcase
    end else if (release_done) begin
      key_held_d = 1'b0;
      item_d     = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
      item_q      <= 2'b00;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      item_q      <= item_d;
    end
  end

  assign col           = ~(4'b0001 << col_idx_q);
  assign key_valid     = key_valid_q;
  assign key_code      = key_code_q;
  assign key_held      = key_held_q;
  assign item_selected = item_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench for keypad_scan_debounce: a keypad matrix model drives the rows from
// the scanned column, and expectations come from key position arithmetic and timing bounds.
module tb_keypad_scan_debounce;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Dt     = 3;
  localparam int MinLat = 2 + (Dt - 1) * ClkDiv + 1;
  localparam int MaxLat = 2 + 5 * ClkDiv + (Dt - 1) * ClkDiv + 1;
  localparam int MinRel = 2 + (Dt - 1) * ClkDiv + 1;
  localparam int MaxRel = 2 + Dt * ClkDiv + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [1:0] item_selected;

  // Keypad model: the pressed key pulls its row low only while its column is driven low.
  logic       press_en = 1'b0;
  logic [1:0] press_r = 2'd0;
  logic [1:0] press_c = 2'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_row = 4'b1111;

  assign row = force_en ? force_row :
               (press_en && (col[press_c] == 1'b0)) ? ~(4'b0001 << press_r) : 4'b1111;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int dbl = 0;
  logic       prev_kv = 1'b0;
  logic [3:0] last_code = 4'd0;
  logic [1:0] last_item = 2'd0;
  logic [1:0] item_map [16];

  always #5 clk = ~clk;

  keypad_scan_debounce #(
    .CLK_DIV       (ClkDiv),
    .DEBOUNCE_TICKS(Dt)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .row          (row),
    .col          (col),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_held     (key_held),
    .item_selected(item_selected)
  );

  task automatic step();
    @(negedge clk);
    if (key_valid) begin
      pulses++;
      last_code = key_code;
      last_item = item_selected;
      if (prev_kv) dbl++;
    end
    prev_kv = key_valid;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_press(input int r, input int c, input int hold, input string tag);
    int p0;
    int lat;
    int rel;
    int code;
    code    = r * 4 + c;
    p0      = pulses;
    lat     = -1;
    press_r = 2'(r);
    press_c = 2'(c);
    press_en = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (key_valid && lat < 0) lat = i + 1;
    end
    check({tag, "_pulses"}, pulses - p0, 1);
    check({tag, "_code"}, last_code, code);
    check({tag, "_item_at_pulse"}, last_item, item_map[code]);
    check({tag, "_lat_in_range"}, (lat >= MinLat && lat <= MaxLat), 1);
    check({tag, "_held"}, key_held, 1);
    check({tag, "_item_held"}, item_selected, item_map[code]);
    press_en = 1'b0;
    rel = 0;
    for (int i = 0; i < 40 && key_held; i++) begin
      step();
      rel++;
    end
    check({tag, "_released"}, key_held, 0);
    check({tag, "_rel_in_range"}, (rel >= MinRel && rel <= MaxRel), 1);
    check({tag, "_item_released"}, item_selected, 0);
    check({tag, "_code_retained"}, key_code, code);
    check({tag, "_no_extra_pulse"}, pulses - p0, 1);
  endtask

  initial begin
    logic [3:0] one4;
    logic [3:0] exp_col;
    logic [3:0] prev_col;
    logic [3:0] cur_col;
    logic       found;
    int         p0;
    int         lat;
    int         r;
    int         c;

    one4 = 4'b0001;
    for (int i = 0; i < 16; i++) item_map[i] = 2'b00;
    item_map[0] = 2'b01;
    item_map[1] = 2'b10;
    item_map[2] = 2'b11;

    // Reset values
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_col", col, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_held", key_held, 0);
    check("rst_item", item_selected, 0);

    // Idle scanning: each column stays low for ClkDiv cycles, in order 0..3
    for (int k = 0; k < 64; k++) begin
      exp_col = ~(one4 << ((k / ClkDiv) % 4));
      check("idle_col", col, exp_col);
      if (k < 63) step();
    end
    check("idle_no_pulse", pulses, 0);

    // Directed presses: row 2 col 1 (code 9, no item) and row 0 col 0 (code 0, item 01)
    run_press(2, 1, 200, "key9");
    run_press(0, 0, 100, "key0");

    // Single-tick glitch on row 0 while column 2 is scanned
    found    = 1'b0;
    prev_col = col;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (col == 4'b1011 && prev_col != 4'b1011) found = 1'b1;
      prev_col = col;
    end
    check("glitch_found_col2", found, 1);
    p0       = pulses;
    press_r  = 2'd0;
    press_c  = 2'd2;
    press_en = 1'b1;
    step();
    step();
    step();
    press_en = 1'b0;
    step();
    step();
    check("glitch_col_held", col, 4'b1011);
    step();
    step();
    step();
    check("glitch_col_resume", col, 4'b0111);
    for (int i = 0; i < 30; i++) step();
    check("glitch_no_pulse", pulses - p0, 0);
    check("glitch_not_held", key_held, 0);

    // Two rows low is never a key: scanning keeps rotating
    p0        = pulses;
    force_row = 4'b1100;
    force_en  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      prev_col = col;
      for (int i = 0; i < 10 && col == prev_col; i++) step();
      cur_col = col;
      for (int i = 0; i < ClkDiv; i++) step();
      check("multi_col_rotates", col, {cur_col[2:0], cur_col[3]});
    end
    force_en = 1'b0;
    check("multi_no_pulse", pulses - p0, 0);
    check("multi_not_held", key_held, 0);

    // Reset while holding key 1, then re-acceptance of the still-held key
    press_r  = 2'd0;
    press_c  = 2'd1;
    press_en = 1'b1;
    for (int i = 0; i < 60 && !key_held; i++) step();
    check("hold_key1_held", key_held, 1);
    check("hold_key1_item", item_selected, 2'b10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_held", key_held, 0);
    check("midrst_item", item_selected, 0);
    check("midrst_col", col, 4'b1110);
    check("midrst_valid", key_valid, 0);
    p0  = pulses;
    lat = -1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      step();
      if (key_valid) lat = i + 1;
    end
    check("reaccept_pulse", pulses - p0, 1);
    check("reaccept_not_early", (lat >= (Dt - 1) * ClkDiv + 1), 1);
    check("reaccept_code", last_code, 1);
    check("reaccept_item", last_item, item_map[1]);
    press_en = 1'b0;
    for (int i = 0; i < 40 && key_held; i++) step();
    check("reaccept_released", key_held, 0);

    // Randomised presses and glitches
    for (int n = 0; n < 16; n++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        p0       = pulses;
        press_r  = 2'(r);
        press_c  = 2'(c);
        press_en = 1'b1;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) step();
        press_en = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("rand_glitch_no_pulse", pulses - p0, 0);
        check("rand_glitch_not_held", key_held, 0);
      end else begin
        run_press(r, c, int'($urandom_range(40, 90)), "rand");
      end
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) step();
    end

    check("no_back_to_back_valid", dbl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
